// File: rtl/ring_arbiter.sv
// ring_arbiter: round-robin doorbell arbiter feeding one playback engine, with ack/timeout watchdogs and guard gap
module ring_arbiter #(
  parameter int N_REQ       = 3,
  parameter int SONG_W      = 3,
  parameter int GAP_CYC     = 50000000,
  parameter int ACK_CYC     = 1024,
  parameter int TIMEOUT_CYC = 536870912
) (
  input  logic                    CK,
  input  logic                    RST,
  input  logic [N_REQ-1:0]        REQ,
  input  logic [N_REQ*SONG_W-1:0] REQ_SONG,
  input  logic                    ENABLE,
  input  logic                    PLAY_BUSY,
  input  logic                    PLAY_DONE,
  output logic                    PLAY_START,
  output logic [SONG_W-1:0]       PLAY_SONG,
  output logic                    ABORT,
  output logic [N_REQ-1:0]        GRANT,
  output logic [N_REQ-1:0]        PENDING,
  output logic                    LOCK
);
  localparam int MAX_AG = GAP_CYC > ACK_CYC ? GAP_CYC : ACK_CYC;
  localparam int MAXC   = MAX_AG > TIMEOUT_CYC ? MAX_AG : TIMEOUT_CYC;
  localparam int CW     = $clog2(MAXC);
  localparam int PW     = $clog2(N_REQ);
  typedef enum logic [2:0] {IDLE, START, WAIT_ACK, PLAY, GAP} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic [N_REQ-1:0] req_q, pend, grant_r, win_oh;
  logic [PW-1:0] ptr, win;
  logic [SONG_W-1:0] song_r, win_song;
  logic found, fire;
  always_comb begin : arb
    int j;
    win = '0;
    found = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      j = int'(ptr) + k;
      if (j >= N_REQ) j = j - N_REQ;
      if (!found && pend[PW'(j)]) begin
        win = PW'(j);
        found = 1'b1;
      end
    end
  end
  assign win_oh   = N_REQ'(1) << win;
  assign win_song = SONG_W'(REQ_SONG >> (win * SONG_W));
  assign fire     = state == IDLE && ENABLE && found;
  always_comb begin
    state_n = state;
    ABORT = 1'b0;
    case (state)
      IDLE:     if (fire) state_n = START;
      START:    state_n = WAIT_ACK;
      WAIT_ACK: if (PLAY_BUSY) state_n = PLAY;
                else if (PLAY_DONE) state_n = GAP;
                else if (cnt == CW'(ACK_CYC - 1)) begin
                  ABORT = 1'b1;
                  state_n = GAP;
                end
      PLAY:     if (PLAY_DONE || !PLAY_BUSY) state_n = GAP;
                else if (cnt == CW'(TIMEOUT_CYC - 1)) begin
                  ABORT = 1'b1;
                  state_n = GAP;
                end
      GAP:      if (cnt == CW'(GAP_CYC - 1)) state_n = IDLE;
      default:  state_n = IDLE;
    endcase
  end
  always_ff @(posedge CK) begin
    if (RST) begin
      state   <= IDLE;
      cnt     <= '0;
      req_q   <= REQ;
      pend    <= '0;
      ptr     <= '0;
      grant_r <= '0;
      song_r  <= '0;
    end else begin
      state <= state_n;
      cnt   <= (state_n != state || state == IDLE) ? '0 : cnt + CW'(1);
      req_q <= REQ;
      pend  <= (pend & ~(fire ? win_oh : '0)) | (REQ & ~req_q);
      if (fire) begin
        ptr     <= (win == PW'(N_REQ - 1)) ? '0 : win + PW'(1);
        grant_r <= win_oh;
        song_r  <= (win_song == '0) ? SONG_W'(1) : win_song;
      end
    end
  end
  assign PLAY_START = state == START;
  assign PLAY_SONG  = song_r;
  assign GRANT      = (state == START || state == WAIT_ACK || state == PLAY) ? grant_r : '0;
  assign PENDING    = pend;
  assign LOCK       = state != IDLE;
endmodule
